// File: rtl/note_sequencer_arb.sv
// note_sequencer_arb
//   Plays a software-loaded queue of reference notes {note, octave, dur} and
//   arbitrates the piano_octave key/octave/enable inputs between that
//   sequence and the live keyboard. While a sequence runs, live keys are
//   masked. When idle, live keys pass through with one cycle of latency.
//
// Ports
//   clk, reset         : system clock, asynchronous active-high reset
//   wr_en/wr_note/
//   wr_octave/wr_dur   : push one queue entry (dropped when full or on abort)
//   start, abort       : begin playback / stop immediately and flush
//   live_keys/_octave/
//   live_en            : live keyboard inputs, ignored while busy
//   key_out/octave_out/
//   play_en_out        : registered drive to piano_octave
//   busy, done         : sequence active / one-cycle normal-drain pulse
//   wr_full, count     : queue status
//   cur_note           : note currently sounding (0 when silent)
module note_sequencer_arb #(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 12,
  parameter int GAP_MS   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_note,
  input  logic [2:0]             wr_octave,
  input  logic [DUR_W-1:0]       wr_dur,
  input  logic                   start,
  input  logic                   abort,
  input  logic [11:0]            live_keys,
  input  logic [2:0]             live_octave,
  input  logic                   live_en,
  output logic [11:0]            key_out,
  output logic [2:0]             octave_out,
  output logic                   play_en_out,
  output logic                   busy,
  output logic                   done,
  output logic                   wr_full,
  output logic [$clog2(DEPTH):0] count,
  output logic [3:0]             cur_note
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
  localparam int MS_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]  GAP_LAST = MS_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t state, state_nxt;

  // ---------------- note queue ----------------
  logic [3:0]       note_mem [DEPTH];
  logic [2:0]       oct_mem  [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push, pop;

  // A full queue drops writes even when a pop happens in the same cycle.
  assign push = wr_en && !wr_full && !abort;
  assign pop  = (state == LOAD) && !abort;

  always_comb begin
    count_nxt = count;
    if (abort)             count_nxt = '0;
    else if (push && !pop) count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      note_mem[wr_ptr] <= wr_note;
      oct_mem[wr_ptr]  <= wr_octave;
      dur_mem[wr_ptr]  <= wr_dur;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      wr_full <= 1'b0;
    end else begin
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count   <= count_nxt;
      wr_full <= (count_nxt == FULL_CNT);
    end
  end

  logic [3:0]       head_note;
  logic [2:0]       head_oct;
  logic [DUR_W-1:0] head_dur;
  assign head_note = note_mem[rd_ptr];
  assign head_oct  = oct_mem[rd_ptr];
  assign head_dur  = dur_mem[rd_ptr];

  // ---------------- duration timers ----------------
  logic [DUR_W-1:0] dur_r;
  logic [MS_W-1:0]  dur_last;
  logic [PRE_W-1:0] pre;
  logic [MS_W-1:0]  ms;
  logic             tick_end, play_end, gap_end;

  assign dur_last = MS_W'(dur_r) - MS_W'(1);
  assign tick_end = (pre == PRE_LAST);
  assign play_end = tick_end && (ms == dur_last);
  assign gap_end  = tick_end && (ms == GAP_LAST);

  // Both timers restart on every state change, so each PLAY/GAP phase is
  // an exact multiple of TICK_DIV cycles with no carried-over phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre   <= '0;
      ms    <= '0;
      dur_r <= DUR_W'(1);
    end else begin
      if (state_nxt != state) begin
        pre <= '0;
        ms  <= '0;
      end else if (state == PLAY || state == GAP) begin
        if (tick_end) begin
          pre <= '0;
          ms  <= ms + MS_W'(1);
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
      // A zero duration plays as 1 ms.
      if (pop) dur_r <= (head_dur == '0) ? DUR_W'(1) : head_dur;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && count != '0) state_nxt = LOAD;
      LOAD: state_nxt = PLAY;
      PLAY: if (play_end) begin
              if (GAP_MS != 0)        state_nxt = GAP;
              else if (count != '0)   state_nxt = LOAD;
              else                    state_nxt = IDLE;
            end
      GAP:  if (gap_end) state_nxt = (count != '0) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  function automatic logic [11:0] onehot(input logic [3:0] n);
    logic [3:0] idx;
    idx = n - 4'd1;
    onehot = '0;
    if (n >= 4'd1 && n <= 4'd12) onehot = 12'd1 << idx;
  endfunction

  // Outputs are computed from the next state and registered, so the first
  // PLAY cycle already shows the note popped during LOAD.
  logic [11:0] key_d;
  logic [2:0]  oct_d;
  logic        en_d, busy_d, done_d;
  logic [3:0]  note_d;

  always_comb begin
    key_d  = key_out;
    oct_d  = octave_out;
    en_d   = play_en_out;
    note_d = cur_note;
    case (state_nxt)
      IDLE: begin
        key_d  = live_keys;
        oct_d  = live_octave;
        en_d   = live_en;
        note_d = '0;
      end
      LOAD, GAP: begin
        key_d  = '0;
        en_d   = 1'b1;
        note_d = '0;
      end
      PLAY: if (state == LOAD) begin
        key_d  = onehot(head_note);
        oct_d  = head_oct;
        en_d   = 1'b1;
        note_d = (head_note <= 4'd12) ? head_note : 4'd0;
      end
      default: ;
    endcase
    busy_d = (state_nxt != IDLE);
    done_d = (state != IDLE) && (state_nxt == IDLE) && !abort;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_out     <= '0;
      octave_out  <= '0;
      play_en_out <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cur_note    <= '0;
    end else begin
      key_out     <= key_d;
      octave_out  <= oct_d;
      play_en_out <= en_d;
      busy        <= busy_d;
      done        <= done_d;
      cur_note    <= note_d;
    end
  end

endmodule

// File: tb/tb_note_sequencer_arb.sv
module tb_note_sequencer_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_note;
  logic [2:0]  wr_octave;
  logic [11:0] wr_dur;
  logic        start, abort;
  logic [11:0] live_keys;
  logic [2:0]  live_octave;
  logic        live_en;
  logic [11:0] key_out;
  logic [2:0]  octave_out;
  logic        play_en_out, busy, done, wr_full;
  logic [2:0]  count;
  logic [3:0]  cur_note;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_sequencer_arb #(.DEPTH(4), .TICK_DIV(4), .DUR_W(12), .GAP_MS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_note(wr_note),
    .wr_octave(wr_octave), .wr_dur(wr_dur), .start(start), .abort(abort),
    .live_keys(live_keys), .live_octave(live_octave), .live_en(live_en),
    .key_out(key_out), .octave_out(octave_out), .play_en_out(play_en_out),
    .busy(busy), .done(done), .wr_full(wr_full), .count(count),
    .cur_note(cur_note)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_entry(input logic [3:0] n, input logic [2:0] o,
                            input logic [11:0] d);
    wr_en = 1'b1; wr_note = n; wr_octave = o; wr_dur = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({key_out, octave_out, play_en_out, busy, done, wr_full, count, cur_note} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: key=%h oct=%0d en=%b busy=%b done=%b full=%b count=%0d note=%0d, want all 0",
               key_out, octave_out, play_en_out, busy, done, wr_full, count, cur_note);
    end
  endtask

  task automatic test_passthrough();
    live_keys = 12'h005; live_octave = 3'd4; live_en = 1'b1;
    tick();
    checks++;
    if (key_out !== 12'h005 || octave_out !== 3'd4 || play_en_out !== 1'b1) begin
      errors++;
      $display("FAIL passthrough_a: key=%h oct=%0d en=%b, want 005 4 1", key_out, octave_out, play_en_out);
    end
    live_keys = 12'hA30; live_octave = 3'd2; live_en = 1'b0;
    tick();
    checks++;
    if (key_out !== 12'hA30 || octave_out !== 3'd2 || play_en_out !== 1'b0) begin
      errors++;
      $display("FAIL passthrough_b: key=%h oct=%0d en=%b, want a30 2 0", key_out, octave_out, play_en_out);
    end
  endtask

  task automatic test_sequence();
    logic [11:0] ek;
    logic [2:0]  eo;
    logic [3:0]  en;
    live_keys = 12'h005; live_octave = 3'd4; live_en = 1'b1;
    push_entry(4'd1, 3'd4, 12'd2);
    push_entry(4'd12, 3'd5, 12'd1);
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL seq_count: count=%0d want 2", count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || key_out !== 12'h000 || play_en_out !== 1'b1) begin
      errors++;
      $display("FAIL seq_load: busy=%b key=%h en=%b want 1 000 1", busy, key_out, play_en_out);
    end
    // c: 0-7 PLAY note1, 8-11 GAP, 12 LOAD, 13-16 PLAY note12, 17-20 GAP, 21 IDLE
    for (int c = 0; c <= 22; c++) begin
      tick();
      ek = (c < 8) ? 12'h001 : (c >= 13 && c <= 16) ? 12'h800 : (c >= 21) ? 12'h005 : 12'h000;
      eo = (c < 13) ? 3'd4 : (c < 21) ? 3'd5 : 3'd4;
      en = (c < 8) ? 4'd1 : (c >= 13 && c <= 16) ? 4'd12 : 4'd0;
      checks++;
      if (key_out !== ek || octave_out !== eo || play_en_out !== 1'b1 ||
          busy !== (c < 21) || done !== (c == 21) || cur_note !== en) begin
        errors++;
        $display("FAIL seq_cycle%0d: key=%h oct=%0d en=%b busy=%b done=%b note=%0d want %h %0d 1 %b %b %0d",
                 c, key_out, octave_out, play_en_out, busy, done, cur_note,
                 ek, eo, (c < 21), (c == 21), en);
      end
    end
    checks++;
    if (count !== 3'd0) begin
      errors++;
      $display("FAIL seq_drained: count=%0d want 0", count);
    end
  endtask

  task automatic test_full();
    wr_en = 1'b1; wr_note = 4'd3; wr_octave = 3'd2; wr_dur = 12'd1;
    repeat (5) tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd4 || wr_full !== 1'b1) begin
      errors++;
      $display("FAIL full_count: count=%0d full=%b want 4 1", count, wr_full);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b1;   // write during the LOAD (pop) cycle while full: dropped
    tick();
    wr_en = 1'b0;
    checks++;
    if (count !== 3'd3 || wr_full !== 1'b0 || key_out !== 12'h004) begin
      errors++;
      $display("FAIL full_pop_write: count=%0d full=%b key=%h want 3 0 004", count, wr_full, key_out);
    end
  endtask

  task automatic test_abort();
    // Continues from the first PLAY cycle left by test_full.
    tick();
    tick();
    checks++;
    if (key_out !== 12'h004 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: key=%h busy=%b want 004 1", key_out, busy);
    end
    abort = 1'b1; wr_en = 1'b1;
    live_keys = 12'h0F0; live_octave = 3'd6; live_en = 1'b1;
    tick();
    abort = 1'b0; wr_en = 1'b0;
    checks++;
    if (busy !== 1'b0 || count !== 3'd0 || wr_full !== 1'b0 || done !== 1'b0 ||
        key_out !== 12'h0F0 || octave_out !== 3'd6 || play_en_out !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: busy=%b count=%0d full=%b done=%b key=%h oct=%0d en=%b want 0 0 0 0 0f0 6 1",
               busy, count, wr_full, done, key_out, octave_out, play_en_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL abort_after: done=%b count=%0d want 0 0", done, count);
    end
    start = 1'b1;   // empty queue: ignored
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_empty_busy: busy=%b want 0", busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL start_empty_done: done=%b want 0", done);
    end
  endtask

  task automatic test_edge();
    logic eb;
    live_keys = 12'h000; live_octave = 3'd1; live_en = 1'b0;
    push_entry(4'd0, 3'd3, 12'd0);
    push_entry(4'd14, 3'd3, 12'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    // c: 0-3 PLAY rest, 4-7 GAP, 8 LOAD, 9-12 PLAY note14, 13-16 GAP, 17 IDLE
    for (int c = 0; c <= 17; c++) begin
      tick();
      eb = (c < 17);
      checks++;
      if (key_out !== 12'h000 || busy !== eb || done !== (c == 17) ||
          cur_note !== 4'd0 || octave_out !== (eb ? 3'd3 : 3'd1) ||
          play_en_out !== eb) begin
        errors++;
        $display("FAIL edge_cycle%0d: key=%h busy=%b done=%b note=%0d oct=%0d en=%b want 000 %b %b 0 %0d %b",
                 c, key_out, busy, done, cur_note, octave_out, play_en_out,
                 eb, (c == 17), (eb ? 3'd3 : 3'd1), eb);
      end
    end
  endtask

  task automatic test_append();
    logic [11:0] ek;
    logic [2:0]  eo;
    live_keys = 12'h005; live_octave = 3'd4; live_en = 1'b1;
    push_entry(4'd5, 3'd2, 12'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    // c: 0-3 PLAY note5, 4-7 GAP, 8 LOAD, 9-12 PLAY note8, 13-16 GAP, 17 IDLE
    for (int c = 0; c <= 17; c++) begin
      tick();
      wr_en = 1'b0;
      start = 1'b0;
      if (c == 0) begin
        wr_en = 1'b1; wr_note = 4'd8; wr_octave = 3'd6; wr_dur = 12'd1;
      end
      if (c == 1) start = 1'b1;
      ek = (c < 4) ? 12'h010 : (c >= 9 && c <= 12) ? 12'h080 : (c == 17) ? 12'h005 : 12'h000;
      eo = (c < 9) ? 3'd2 : (c < 17) ? 3'd6 : 3'd4;
      checks++;
      if (key_out !== ek || octave_out !== eo || busy !== (c < 17) || done !== (c == 17)) begin
        errors++;
        $display("FAIL append_cycle%0d: key=%h oct=%0d busy=%b done=%b want %h %0d %b %b",
                 c, key_out, octave_out, busy, done, ek, eo, (c < 17), (c == 17));
      end
      if (c == 2) begin
        checks++;
        if (count !== 3'd1) begin
          errors++;
          $display("FAIL append_count: count=%0d want 1", count);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_note = '0; wr_octave = '0; wr_dur = '0;
    start = 1'b0; abort = 1'b0;
    live_keys = 12'h005; live_octave = 3'd4; live_en = 1'b1;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_passthrough();
    test_sequence();
    test_full();
    test_abort();
    test_edge();
    test_append();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_sequencer_arb.md
# note_sequencer_arb

Plays a software-loaded queue of reference notes (note, octave, duration) for pitch-training prompts, and arbitrates the `piano_octave` key/octave/enable inputs between this sequence and the live PS/2 keyboard. It sits between the keyboard key-status logic and `piano_octave`. While a sequence runs it owns the tone generator, and live keys are masked. When idle, live keys pass through.

## Interface
- `DEPTH`, 16: note queue entries (power of 2, ≥2)
- `TICK_DIV`, 100000: `clk` cycles per 1 ms tick
- `DUR_W`, 12: duration field width (ms)
- `GAP_MS`, 20: silent gap after each note (ms); 0 means no gap

- `clk`  in  1  system clock (100 MHz)
- `reset`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  push one entry into the queue
- `wr_note`  in  4  0 = rest, 1..12 = C..B, 13..15 = treated as rest
- `wr_octave`  in  3  octave for the entry
- `wr_dur`  in  `DUR_W`  note length in ms; 0 is treated as 1
- `start`  in  1  pulse: begin playing the queue
- `abort`  in  1  pulse: stop immediately and flush the queue
- `live_keys`  in  12  live key status (bit 0 = C)
- `live_octave`  in  3  live octave select
- `live_en`  in  1  live play enable
- `key_out`  out  12  to `piano_octave.piano_keys`
- `octave_out`  out  3  to `piano_octave.octave_num`
- `play_en_out`  out  1  to `piano_octave.play_en`
- `busy`  out  1  sequence active (any state other than IDLE)
- `done`  out  1  one-cycle pulse when the queue drains normally
- `wr_full`  out  1  queue full
- `count`  out  $clog2(DEPTH)+1  number of queued entries
- `cur_note`  out  4  note currently sounding; 0 in IDLE/GAP

## Operation
- Queue: synchronous FIFO of {note, octave, dur}. A write is accepted when `wr_en` is high and `!wr_full` in that cycle. When full, a write is dropped, even if a pop happens in the same cycle. Writes are accepted in every state, so entries can be appended during playback.
- FSM states:
  - IDLE: outputs mirror live inputs. `start` with `count != 0` moves to LOAD. `start` with an empty queue is ignored and produces no `done`.
  - LOAD (1 cycle): pop the head into the note/octave/duration registers, then go to PLAY.
  - PLAY: `key_out` = one-hot(note−1), or 0 for a rest or note 13..15. `octave_out` = entry octave. `play_en_out` = 1. Lasts max(dur,1)·`TICK_DIV` cycles. Then go to GAP, or skip GAP when `GAP_MS`=0.
  - GAP: `key_out` = 0. `octave_out` is held. `play_en_out` = 1. Lasts `GAP_MS`·`TICK_DIV` cycles.
  - After a note completes (end of GAP, or end of PLAY when `GAP_MS`=0): if the queue is non-empty, go to LOAD; otherwise pulse `done` and go to IDLE.
- Timers: the ms prescaler (0..`TICK_DIV`−1) and the ms counter both clear on entry to PLAY and to GAP. Durations are exact and have no phase error.
- `start` while `busy` is ignored.
- `abort` in any state: next state is IDLE, the FIFO is flushed (`count`=0), and no `done` is produced. If `abort` coincides with `start` or `wr_en`, abort wins: the write is dropped and the start is ignored.
- `live_keys`, `live_octave` and `live_en` are ignored while `busy`.

## Timing
- All outputs are registered.
- Reset values: `key_out`=0, `octave_out`=0, `play_en_out`=0, `busy`=0, `done`=0, `wr_full`=0, `count`=0, `cur_note`=0, FSM=IDLE.
- Live passthrough latency is 1 cycle.
- `start` sampled at cycle t: LOAD at t+1, first PLAY cycle (new `key_out`) at t+2. `busy` rises at t+1.
- Note-to-note in steady state: the last GAP cycle is followed by 1 LOAD cycle, then PLAY. `key_out` is 0 during LOAD.
- `done` goes high in the first IDLE cycle, for 1 cycle. `busy` is low in that same cycle.
- Return to IDLE (normal or abort): passthrough is restored on the first IDLE cycle and reflects the inputs sampled one cycle earlier.
- `count` and `wr_full` update the cycle after the push or pop.

## Test plan
Bench parameters: `DEPTH`=4, `TICK_DIV`=4, `GAP_MS`=1.
- Reset → live passthrough: idle with `live_keys`=12'h005, `live_octave`=4, `live_en`=1 → one cycle later `key_out`=12'h005, `octave_out`=4, `play_en_out`=1.
- Push {1,4,2} and {12,5,1}, then pulse `start` → `key_out`=12'h001 for 8 cycles, 0 for 4 (GAP), 0 for 1 (LOAD), 12'h800 with `octave_out`=5 for 4 cycles, then 4 GAP cycles → `done` pulse, `busy`=0.
- Push 5 entries while idle → `count`=4, `wr_full`=1, 5th dropped. Pop + write in the same full cycle → `count`=3.
- `abort` during the 3rd PLAY cycle → next cycle `busy`=0, `count`=0, passthrough active, no `done`.
- Edge fields: entry {0,3,0} → `key_out`=0, `play_en_out`=1, PLAY lasts 4 cycles. Entry {14,3,1} → rest behaviour.
- Append during PLAY of the only entry → the appended note plays after GAP+LOAD, `done` appears only after it finishes. `start` during PLAY has no effect.
